// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler: shares one 16-bit SPI DAC serializer between NUM_CH channels
// with round-robin issue and a common LDAC strobe after each batch drains.
module dac_update_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CH_BITS     = 2,
    parameter int DATA_BITS   = 12,
    parameter int LDAC_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [CH_BITS-1:0]   wr_ch,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 spi_start,
    output logic [15:0]          spi_word,
    input  logic                 spi_busy,
    output logic                 ldac_n,
    output logic [NUM_CH-1:0]    pending,
    output logic                 idle
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, LDAC} state_t;
    localparam int CW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;

    state_t               state_q, state_d;
    logic [NUM_CH-1:0]    pending_q, pending_d;
    logic [DATA_BITS-1:0] shadow_q [NUM_CH];
    logic [DATA_BITS-1:0] shadow_d [NUM_CH];
    logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d, sel;
    logic [15:0]          spi_word_q, spi_word_d;
    logic                 dirty_q, dirty_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 go;
    int                   idx;

    // Word, pending clear and pointer update all happen on the edge entering ISSUE,
    // so a write landing on that same edge or during ISSUE survives as pending.
    always_comb begin
        sel = '0;
        idx = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pending_q[idx]) sel = CH_BITS'(idx);
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        rr_ptr_d   = rr_ptr_q;
        spi_word_d = spi_word_q;
        dirty_d    = dirty_q;
        cnt_d      = cnt_q;
        go         = 1'b0;
        case (state_q)
            IDLE:    go = enable && (|pending_q) && !spi_busy;
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: state_d = spi_busy ? WAIT_LO : WAIT_HI;
            WAIT_LO: begin
                if (!spi_busy) begin
                    if (enable && (|pending_q)) begin
                        go = 1'b1;
                    end else if (dirty_q) begin
                        state_d = LDAC;
                        cnt_d   = CW'(LDAC_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LDAC: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    dirty_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            state_d        = ISSUE;
            pending_d[sel] = 1'b0;
            spi_word_d     = {2'b00, 2'(sel), shadow_q[sel]};
            rr_ptr_d       = (int'(sel) == NUM_CH - 1) ? '0 : sel + CH_BITS'(1);
            dirty_d        = 1'b1;
        end
        if (wr_en && int'(wr_ch) < NUM_CH) begin
            shadow_d[wr_ch]  = wr_data;
            pending_d[wr_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            shadow_q   <= '{default: '0};
            rr_ptr_q   <= '0;
            spi_word_q <= '0;
            dirty_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            rr_ptr_q   <= rr_ptr_d;
            spi_word_q <= spi_word_d;
            dirty_q    <= dirty_d;
            cnt_q      <= cnt_d;
        end
    end

    assign spi_start = (state_q == ISSUE);
    assign spi_word  = spi_word_q;
    assign ldac_n    = (state_q != LDAC);
    assign pending   = pending_q;
    assign idle      = (state_q == IDLE) && (pending_q == '0);
endmodule
